// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time and
// hands each fetched word to decode, dropping fetches made stale by a redirect.
module ifu_fetch #(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        DATA_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h8000_0000),
    parameter int unsigned        PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [DATA_W-1:0] imem_resp_data,
    input  logic              imem_resp_err,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              discard, discard_n;
    logic [DATA_W-1:0] inst_r, inst_n;
    logic              err_r, err_n;

    logic misaligned;
    logic req_fire;

    assign misaligned     = (pc[1:0] != 2'b00);
    assign imem_req_valid = (state == S_REQ) && !misaligned && !rst;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_OUT) && !rst;
    assign inst_out       = inst_r;
    assign inst_pc        = pc;
    assign fetch_err      = err_r;

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        state_n   = state;
        pc_n      = pc;
        discard_n = discard;
        inst_n    = inst_r;
        err_n     = err_r;

        unique case (state)
            S_REQ: begin
                // A redirect while idle in REQ just retargets the next request.
                if (req_fire) begin
                    state_n   = S_WAIT;
                    discard_n = redirect_valid;
                end else if (misaligned && !redirect_valid) begin
                    inst_n  = '0;
                    err_n   = 1'b1;
                    state_n = S_OUT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (discard || redirect_valid) begin
                        discard_n = 1'b0;
                        state_n   = S_REQ;
                    end else begin
                        inst_n  = imem_resp_data;
                        err_n   = imem_resp_err;
                        state_n = S_OUT;
                    end
                end else if (redirect_valid) begin
                    discard_n = 1'b1;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    state_n = S_REQ;
                end else if (inst_ready) begin
                    pc_n    = pc + ADDR_W'(PC_STEP);
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase

        if (redirect_valid) begin
            pc_n = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples the pre-edge values computed above.
        if (rst) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            discard <= 1'b0;
            inst_r  <= '0;
            err_r   <= 1'b0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            discard <= discard_n;
            inst_r  <= inst_n;
            err_r   <= err_n;
        end
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
Instruction fetch stage of the NPC core. It sits directly upstream of the decode stage, whose opcode/funct key-select muxes consume `inst_out`. The block holds the PC and issues one request at a time to instruction memory over a valid/ready request and response interface. It presents each fetched instruction to decode with a valid/ready handshake and accepts branch/jump redirects from execute, discarding stale in-flight fetches.

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h8000_0000, PC value loaded on reset
PC_STEP, 4, PC increment per accepted instruction

Ports:
clk  input  1  single clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
redirect_valid  input  1  execute requests a PC change this cycle
redirect_pc  input  ADDR_W  redirect target
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  ADDR_W  fetch address (equals current PC)
imem_resp_valid  input  1  response data valid (memory always accepts responses)
imem_resp_data  input  DATA_W  fetched instruction word
imem_resp_err  input  1  memory access fault
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst_out  output  DATA_W  instruction to decode
inst_pc  output  ADDR_W  PC of inst_out
fetch_err  output  1  instruction carries a fetch fault (access or misaligned)

Behaviour:
- State registers: pc, state in {REQ, WAIT, OUT}, discard flag, inst_r, err_r.
- Reset (rst=1 at edge): pc=RESET_PC, state=REQ, discard=0, inst_r=0, err_r=0.
  - While rst=1, `imem_req_valid` and `inst_valid` are forced to 0.
  - Reset mid-transaction abandons it. Any later `imem_resp_valid` arriving in REQ is ignored.
- Outputs: imem_req_valid=(state==REQ && pc[1:0]==0 && !rst); imem_req_addr=pc; inst_valid=(state==OUT && !rst); inst_out=inst_r; inst_pc=pc; fetch_err=err_r.
- REQ:
  - pc[1:0]!=0: no request; inst_r=0, err_r=1, go OUT next cycle.
  - req_valid && req_ready: go WAIT.
  - `imem_resp_valid` is ignored in REQ.
- WAIT, on resp_valid:
  - discard=1: drop the data, clear discard, go REQ.
  - Otherwise: inst_r=resp_data, err_r=resp_err, go OUT.
- OUT:
  - inst_out, inst_pc and fetch_err are held stable while inst_valid && !inst_ready.
  - On inst_ready: pc=pc+PC_STEP, go REQ. Addition is modulo 2^ADDR_W, so 0xFFFF_FFFC wraps to 0.
- Redirect, any state: pc=redirect_pc at the edge. Redirect has priority over increment.
  - REQ without handshake: stay REQ; the next request uses the new pc.
  - REQ with handshake in the same cycle: go WAIT with discard=1, because the old address was already issued.
  - WAIT without resp_valid: discard=1, stay WAIT.
  - WAIT with resp_valid in the same cycle: drop the response, discard=0, go REQ.
  - OUT, with or without inst_ready: go REQ. inst_valid deasserts next cycle; no increment.
  - Back-to-back redirects: the last one wins. discard stays 1 until exactly one response is consumed.
- Only one outstanding memory request at any time.
- Latency with zero-wait memory (req_ready=1, resp_valid in the cycle after acceptance):
  - req accepted at cycle N, inst_valid at N+2.
  - Steady throughput: one instruction per 3 cycles with inst_ready=1.
- Misaligned redirect target: a faulting instruction is delivered with no memory traffic; inst_pc shows the misaligned pc.

Test Plan:
- Reset, then zero-wait memory returning 0x0000_0013, inst_ready=1:
  - First req addr=0x8000_0000; inst_valid 2 cycles after acceptance with inst_out=0x13, inst_pc=0x8000_0000.
  - Next req addr=0x8000_0004.
- Decode backpressure: inst_ready=0 for 5 cycles.
  - inst_valid, inst_out and inst_pc are stable throughout; no new imem request.
  - pc advances by exactly 4 after ready rises.
- Redirect to 0x8000_0100 while in WAIT, then response 0xDEAD_BEEF arrives:
  - Response is dropped; inst_valid never asserts for it.
  - Next req addr=0x8000_0100.
- Redirect in the same cycle as inst_ready in OUT, target 0x8000_0040:
  - No increment; next req addr=0x8000_0040.
- Redirect to 0x8000_0102:
  - No imem_req_valid; inst_valid with fetch_err=1, inst_out=0, inst_pc=0x8000_0102.
- Edge cases:
  - PC at 0xFFFF_FFFC, then accept: next addr=0x0000_0000.
  - imem_resp_err=1: fetch_err=1 on the delivered instruction.
  - rst asserted in WAIT: next req addr=RESET_PC; a late response is ignored.
